// File: rtl/sd_switch_if.sv
`default_nettype none
// ============================================================================
// Module  : sd_switch_if
// Brief   : SD socket switch pins, event-clear strobes and conditioned outputs.
// Revision: 1.0  initial release
// ============================================================================
interface sd_switch_if;
    logic       wp_n_raw;
    logic       cd_n_raw;
    logic [1:0] evt_clr;
    logic       irq_en;
    logic       wp_n_out;
    logic       cd_n_out;
    logic       wp_evt;
    logic       cd_evt;
    logic       irq;

    modport master (
        output wp_n_raw, cd_n_raw, evt_clr, irq_en,
        input  wp_n_out, cd_n_out, wp_evt, cd_evt, irq
    );

    modport slave (
        input  wp_n_raw, cd_n_raw, evt_clr, irq_en,
        output wp_n_out, cd_n_out, wp_evt, cd_evt, irq
    );
endinterface
`default_nettype wire

// File: rtl/sd_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : sd_switch_conditioner
// Brief   : Synchronises and debounces the SD write-protect and card-detect
//           switches, with sticky change flags and a maskable interrupt.
// Revision: 1.0  initial release
// ============================================================================
module sd_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input wire         clk,
    input wire         reset_n,
    sd_switch_if.slave sw
);

    typedef enum logic [1:0] {
        STABLE_HI = 2'd0,
        WAIT_LO   = 2'd1,
        STABLE_LO = 2'd2,
        WAIT_HI   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_out;
    logic [1:0] w_evt;
    logic       r_irq;

    // Bit 0 is write-protect, bit 1 is card-detect throughout.
    assign w_raw = {sw.cd_n_raw, sw.wp_n_raw};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_chan
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_out;
        logic             w_out_nxt;
        logic             r_evt;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            unique case (r_state)
                STABLE_HI: begin
                    if (!r_sync2[g]) begin
                        w_state_nxt = WAIT_LO;
                        w_cnt_nxt   = c_one;
                    end
                end
                WAIT_LO: begin
                    if (r_sync2[g])
                        w_state_nxt = STABLE_HI;
                    else if (r_cnt == c_last)
                        w_state_nxt = STABLE_LO;
                    else
                        w_cnt_nxt = r_cnt + c_one;
                end
                STABLE_LO: begin
                    if (r_sync2[g]) begin
                        w_state_nxt = WAIT_HI;
                        w_cnt_nxt   = c_one;
                    end
                end
                WAIT_HI: begin
                    if (!r_sync2[g])
                        w_state_nxt = STABLE_LO;
                    else if (r_cnt == c_last)
                        w_state_nxt = STABLE_HI;
                    else
                        w_cnt_nxt = r_cnt + c_one;
                end
                default: w_state_nxt = STABLE_HI;
            endcase
            w_out_nxt = (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
        end

        // A new change outranks a coincident clear so no edge is ever lost.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_state <= STABLE_HI;
                r_cnt   <= '0;
                r_out   <= 1'b1;
                r_evt   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
                r_evt   <= (w_out_nxt != r_out) | (r_evt & ~sw.evt_clr[g]);
            end
        end

        assign w_out[g] = r_out;
        assign w_evt[g] = r_evt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_irq <= 1'b0;
        else
            r_irq <= sw.irq_en & (|w_evt);
    end

    assign sw.wp_n_out = w_out[0];
    assign sw.cd_n_out = w_out[1];
    assign sw.wp_evt   = w_evt[0];
    assign sw.cd_evt   = w_evt[1];
    assign sw.irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sd_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_switch_conditioner
// Brief   : Directed bench for sd_switch_conditioner with a cycle-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_sd_switch_conditioner;

    localparam int c_deb = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;

    sd_switch_if sw ();

    sd_switch_conditioner #(
        .DEBOUNCE_CYCLES(c_deb),
        .CNT_W          (16)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw     (sw.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: an output takes the synchronised level once that level has
    // disagreed with it for c_deb consecutive sampling edges.
    logic [1:0] m_s1, m_s2, m_out, m_evt;
    int         m_run [2];
    logic       m_irq;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [1:0] n_out, n_evt, raw;
        int         n_run [2];
        if (!reset_n) begin
            m_s1     <= 2'b11;
            m_s2     <= 2'b11;
            m_out    <= 2'b11;
            m_evt    <= 2'b00;
            m_run[0] <= 0;
            m_run[1] <= 0;
            m_irq    <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            raw = {sw.cd_n_raw, sw.wp_n_raw};
            for (int ch = 0; ch < 2; ch++) begin
                n_out[ch] = m_out[ch];
                n_run[ch] = (m_s2[ch] != m_out[ch]) ? m_run[ch] + 1 : 0;
                if (n_run[ch] == c_deb) begin
                    n_out[ch] = m_s2[ch];
                    n_run[ch] = 0;
                end
                n_evt[ch] = (n_out[ch] != m_out[ch]) || (m_evt[ch] && !sw.evt_clr[ch]);
            end
            m_irq    <= sw.irq_en & (|m_evt);
            m_out    <= n_out;
            m_evt    <= n_evt;
            m_run[0] <= n_run[0];
            m_run[1] <= n_run[1];
            m_s2     <= m_s1;
            m_s1     <= raw;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_wp_out", sw.wp_n_out, m_out[0]);
            check("cyc_cd_out", sw.cd_n_out, m_out[1]);
            check("cyc_wp_evt", sw.wp_evt,   m_evt[0]);
            check("cyc_cd_evt", sw.cd_evt,   m_evt[1]);
            check("cyc_irq",    sw.irq,      m_irq);
        end
    end

    int   wp_rises = 0;
    logic wp_prev  = 1'b0;
    always @(negedge clk) begin
        if (sw.wp_evt === 1'b1 && wp_prev === 1'b0)
            wp_rises <= wp_rises + 1;
        wp_prev <= sw.wp_evt;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int base;

    initial begin
        sw.wp_n_raw = 1'b1;
        sw.cd_n_raw = 1'b1;
        sw.evt_clr  = 2'b00;
        sw.irq_en   = 1'b1;
        reset_n     = 1'b0;
        step(3);
        check("rst_wp_out", sw.wp_n_out, 1);
        check("rst_cd_out", sw.cd_n_out, 1);
        check("rst_wp_evt", sw.wp_evt, 0);
        check("rst_cd_evt", sw.cd_evt, 0);
        check("rst_irq",    sw.irq, 0);
        reset_n = 1'b1;
        step(3);

        // Clean card-detect step: falls on the sixth edge, irq one later.
        sw.cd_n_raw = 1'b0;
        step(5);
        check("cd_step_e5", sw.cd_n_out, 1);
        step(1);
        check("cd_step_e6", sw.cd_n_out, 0);
        check("cd_step_evt", sw.cd_evt, 1);
        check("cd_step_irq_e6", sw.irq, 0);
        step(1);
        check("cd_step_irq_e7", sw.irq, 1);
        sw.evt_clr = 2'b10;
        step(1);
        sw.evt_clr = 2'b00;
        check("cd_clr_evt", sw.cd_evt, 0);
        step(1);
        check("cd_clr_irq", sw.irq, 0);

        // Short write-protect pulse, gap, then a held low.
        base = wp_rises;
        sw.wp_n_raw = 1'b0;
        step(3);
        sw.wp_n_raw = 1'b1;
        step(1);
        sw.wp_n_raw = 1'b0;
        step(5);
        check("wp_bounce_e5", sw.wp_n_out, 1);
        step(1);
        check("wp_bounce_e6", sw.wp_n_out, 0);
        check("wp_bounce_evt", sw.wp_evt, 1);
        step(1);
        check("wp_evt_count", wp_rises - base, 1);
        sw.evt_clr = 2'b01;
        step(1);
        sw.evt_clr = 2'b00;
        check("wp_clr_evt", sw.wp_evt, 0);

        // Set beats a coincident clear.
        sw.cd_n_raw = 1'b1;
        step(6);
        check("cd_rise_out", sw.cd_n_out, 1);
        check("cd_rise_evt", sw.cd_evt, 1);
        sw.cd_n_raw = 1'b0;
        step(5);
        sw.evt_clr = 2'b10;
        step(1);
        sw.evt_clr = 2'b00;
        check("setclr_out", sw.cd_n_out, 0);
        check("setclr_evt", sw.cd_evt, 1);
        step(2);
        sw.evt_clr = 2'b10;
        step(1);
        sw.evt_clr = 2'b00;
        check("late_clr_evt", sw.cd_evt, 0);

        // Reset in the middle of a pending fall.
        sw.cd_n_raw = 1'b1;
        step(6);
        sw.evt_clr = 2'b10;
        step(1);
        sw.evt_clr = 2'b00;
        sw.cd_n_raw = 1'b0;
        step(4);
        check("midwait_out", sw.cd_n_out, 1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("midrst_cd_out", sw.cd_n_out, 1);
        check("midrst_cd_evt", sw.cd_evt, 0);
        check("midrst_wp_evt", sw.wp_evt, 0);
        step(5);
        check("postrst_e5", sw.cd_n_out, 1);
        step(1);
        check("postrst_cd_out", sw.cd_n_out, 0);
        check("postrst_cd_evt", sw.cd_evt, 1);
        check("postrst_wp_out", sw.wp_n_out, 0);
        check("postrst_wp_evt", sw.wp_evt, 1);
        sw.evt_clr = 2'b11;
        step(1);
        sw.evt_clr = 2'b00;

        // Both channels together with the interrupt masked.
        sw.irq_en   = 1'b0;
        step(2);
        sw.wp_n_raw = 1'b1;
        sw.cd_n_raw = 1'b1;
        step(5);
        check("both_e5_wp", sw.wp_n_out, 0);
        check("both_e5_cd", sw.cd_n_out, 0);
        step(1);
        check("both_wp_out", sw.wp_n_out, 1);
        check("both_cd_out", sw.cd_n_out, 1);
        check("both_wp_evt", sw.wp_evt, 1);
        check("both_cd_evt", sw.cd_evt, 1);
        check("both_irq_masked", sw.irq, 0);
        step(2);
        check("both_irq_still", sw.irq, 0);
        sw.irq_en = 1'b1;
        step(1);
        check("irq_unmask", sw.irq, 1);
        sw.irq_en = 1'b0;
        step(1);
        check("irq_remask", sw.irq, 0);
        check("remask_wp_evt", sw.wp_evt, 1);
        check("remask_cd_evt", sw.cd_evt, 1);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
